// File: rtl/arb_pkt_mux.sv
// Packet-atomic N:1 mux in front of an external round-robin arbiter.
// A grant locks the mux onto one client until that client's last beat is
// taken; beats pass through a single-stage output register.
module arb_pkt_mux #(
    parameter int CLIENTS = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CLIENTS-1:0]         in_valid,
    output logic [CLIENTS-1:0]         in_ready,
    input  logic [CLIENTS*DATA_W-1:0]  in_data,
    input  logic [CLIENTS-1:0]         in_last,
    output logic [CLIENTS-1:0]         arb_req,
    input  logic [CLIENTS-1:0]         arb_gnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [$clog2(CLIENTS)-1:0] out_src,
    output logic                       busy,
    output logic                       gnt_err,
    output logic [15:0]                pkt_cnt
);
    localparam int SEL_W = $clog2(CLIENTS);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic              gnt_err_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_last_reg;
    logic [SEL_W-1:0]  out_src_reg;
    logic [15:0]       pkt_cnt_reg;

    logic [DATA_W-1:0] data_arr [CLIENTS];
    logic              gnt_onehot;
    logic              gnt_subset;
    logic              gnt_ok;
    logic [SEL_W-1:0]  gnt_idx;
    logic              out_free;
    logic              xfer;
    logic              out_xfer;

    // Split the flat payload bus into one word per client for indexing by sel.
    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_data
            assign data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Arbiter requests are only exposed while idle so the rotation stays put mid-packet.
    assign arb_req = (state_reg == IDLE) ? in_valid : '0;

    // A usable grant is exactly one bit and only on a requesting client.
    assign gnt_onehot = (arb_gnt != '0) && ((arb_gnt & (arb_gnt - CLIENTS'(1))) == '0);
    assign gnt_subset = (arb_gnt & ~arb_req) == '0;
    assign gnt_ok     = gnt_onehot && gnt_subset;

    // Encode the one-hot grant into a client index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

    // The output stage can take a beat when empty or draining this cycle.
    assign out_free = !out_valid_reg || out_ready;
    assign xfer     = (state_reg == LOCK) && in_valid[sel_reg] && out_free;
    assign out_xfer = out_valid_reg && out_ready;

    // Only the locked client sees ready, and only when the output stage has room.
    generate
        for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_ready
            assign in_ready[gi] = (state_reg == LOCK) && (sel_reg == SEL_W'(gi)) && out_free;
        end
    endgenerate

    // Arbitration / packet-lock FSM with the sticky grant-protocol error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_reg     <= '0;
            gnt_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_req != '0) begin
                        if (gnt_ok) begin
                            sel_reg   <= gnt_idx;
                            state_reg <= LOCK;
                        end else begin
                            gnt_err_reg <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (xfer && in_last[sel_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Single-stage output register: load wins over drain so back-to-back beats flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_arr[sel_reg];
            out_last_reg  <= in_last[sel_reg];
            out_src_reg   <= sel_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Delivered-packet counter, saturating so it never wraps back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_reg <= '0;
        end else if (out_xfer && out_last_reg && (pkt_cnt_reg != 16'hFFFF)) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
    end

    assign busy      = (state_reg == LOCK);
    assign gnt_err   = gnt_err_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;
    assign pkt_cnt   = pkt_cnt_reg;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Scoreboard bench for arb_pkt_mux: per-client expected-beat queues plus a
// grant-order queue from the bench's round-robin arbiter; a monitor checks
// every output transfer against them, alongside directed latency, throughput,
// bad-grant and mid-packet reset scenarios.
module tb_arb_pkt_mux;
    localparam int CLIENTS = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = $clog2(CLIENTS);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [CLIENTS-1:0]         in_valid;
    logic [CLIENTS-1:0]         in_ready;
    logic [CLIENTS*DATA_W-1:0]  in_data;
    logic [CLIENTS-1:0]         in_last;
    logic [CLIENTS-1:0]         arb_req;
    logic [CLIENTS-1:0]         arb_gnt;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_last;
    logic [SEL_W-1:0]           out_src;
    logic                       busy;
    logic                       gnt_err;
    logic [15:0]                pkt_cnt;

    arb_pkt_mux #(.CLIENTS(CLIENTS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .arb_req(arb_req), .arb_gnt(arb_gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_src(out_src),
        .busy(busy), .gnt_err(gnt_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t pend_q [CLIENTS][$];
    beat_t exp_q  [CLIENTS][$];
    int    grant_q [$];
    beat_t last_pkt [8];

    int    checks = 0;
    int    errors = 0;
    int    bubble_pct = 0;
    bit    rand_ready = 0;
    logic  ready_fixed = 1'b1;
    bit    flush = 0;
    bit    force_bad = 0;
    logic [CLIENTS-1:0] bad_gnt = '0;
    int    rr_ptr = 0;
    int    gnt_idx;
    int    out_beats = 0;
    bit    in_pkt = 0;
    int    cur_src = 0;
    logic [15:0] model_cnt = 16'd0;
    bit    hold_prev = 0;
    logic [DATA_W-1:0] prev_data;
    logic  prev_last;
    logic [SEL_W-1:0] prev_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic post_pkt(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = (i == len - 1);
            if (i < 8) last_pkt[i] = b;
            pend_q[c].push_back(b);
            exp_q[c].push_back(b);
        end
        $display("post client %0d len %0d", c, len);
    endtask

    // Round-robin arbiter model: first requester at or after rr_ptr, or a forced bad grant.
    always_comb begin
        bit found;
        int c;
        found   = 0;
        c       = 0;
        arb_gnt = '0;
        gnt_idx = 0;
        if (force_bad) begin
            arb_gnt = bad_gnt;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                c = (rr_ptr + i) % CLIENTS;
                if (arb_req[c] && !found) begin
                    found      = 1;
                    arb_gnt[c] = 1'b1;
                    gnt_idx    = c;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && !force_bad && !busy && arb_req != '0)
            rr_ptr <= (gnt_idx + 1) % CLIENTS;
    end

    // Client drivers: present queued beats with random bubbles, hold until accepted.
    initial begin
        logic [CLIENTS-1:0] hs;
        beat_t b;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        hs        = '0;
        forever begin
            @(negedge clk);
            if (flush) begin
                for (int k = 0; k < CLIENTS; k++) pend_q[k].delete();
                in_valid = '0;
                hs       = '0;
                flush    = 0;
            end else begin
                hs = in_valid & in_ready;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < CLIENTS; k++) begin
                if (hs[k]) in_valid[k] = 1'b0;
                if (!in_valid[k] && pend_q[k].size() > 0 && $urandom_range(99) >= bubble_pct) begin
                    b = pend_q[k].pop_front();
                    in_valid[k] = 1'b1;
                    in_data[k*DATA_W +: DATA_W] = b.data;
                    in_last[k] = b.last;
                end
            end
            out_ready = rand_ready ? ($urandom_range(99) < 70) : ready_fixed;
        end
    end

    // Monitor: protocol invariants every cycle, scoreboard on every output transfer.
    initial begin
        int s;
        int g;
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 0;
                continue;
            end
            chk("pkt_cnt", 64'(pkt_cnt), 64'(model_cnt));
            chk("arb_req", 64'(arb_req), 64'(busy ? {CLIENTS{1'b0}} : in_valid));
            chk("in_ready_onehot", 64'($onehot0(in_ready)), 64'(1));
            if (!busy || (out_valid && !out_ready))
                chk("in_ready_zero", 64'(in_ready), 64'(0));
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'(out_data), 64'(prev_data));
                chk("hold_last", 64'(out_last), 64'(prev_last));
                chk("hold_src", 64'(out_src), 64'(prev_src));
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            prev_src  = out_src;
            if (!busy && arb_req != '0 && !force_bad)
                grant_q.push_back(gnt_idx);
            if (out_valid && out_ready) begin
                out_beats++;
                s = int'(out_src);
                if (!in_pkt) begin
                    chk("grant_avail", 64'(grant_q.size() != 0), 64'(1));
                    if (grant_q.size() != 0) begin
                        g = grant_q.pop_front();
                        chk("pkt_src", 64'(out_src), 64'(g));
                    end
                    in_pkt  = 1;
                    cur_src = s;
                end else begin
                    chk("pkt_atomic", 64'(out_src), 64'(cur_src));
                end
                chk("beat_avail", 64'(exp_q[s].size() != 0), 64'(1));
                if (exp_q[s].size() != 0) begin
                    b = exp_q[s].pop_front();
                    chk("out_data", 64'(out_data), 64'(b.data));
                    chk("out_last", 64'(out_last), 64'(b.last));
                end
                $display("beat src %0d data %08h last %0d", s, out_data, out_last);
                if (out_last) begin
                    in_pkt = 0;
                    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        bit done;
        bit empty;
        done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            #1;
            empty = 1;
            for (int k = 0; k < CLIENTS; k++)
                if (pend_q[k].size() != 0 || exp_q[k].size() != 0) empty = 0;
            if (empty && !out_valid && !busy && in_valid == '0) done = 1;
        end
        chk("drain", 64'(done), 64'(1));
    endtask

    // Global time bound so the run always ends.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int base;
        int cyc_rec [$];
        int src_rec [$];

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gnt_err", 64'(gnt_err), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Client 2, three beats, out_ready high: minimum latency and consecutive beats.
        post_pkt(2, 3);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (in_valid[2]) found = 1;
        end
        chk("lat_start", 64'(found), 64'(1));
        if (found) begin
            chk("lat_arb_busy", 64'(busy), 64'(0));
            chk("lat_arb_ov", 64'(out_valid), 64'(0));
            @(negedge clk);
            chk("lat_xfer_busy", 64'(busy), 64'(1));
            chk("lat_xfer_ov", 64'(out_valid), 64'(0));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("lat_ov", 64'(out_valid), 64'(1));
                chk("lat_data", 64'(out_data), 64'(last_pkt[j].data));
                chk("lat_last", 64'(out_last), 64'(j == 2));
                chk("lat_src", 64'(out_src), 64'(2));
            end
        end
        wait_drain(100);
        chk("lat_pkt_cnt", 64'(pkt_cnt), 64'(1));

        // Clients 0 and 1 streaming single-beat packets: alternate, one beat per two cycles.
        for (int i = 0; i < 4; i++) begin
            post_pkt(0, 1);
            post_pkt(1, 1);
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                cyc_rec.push_back(c);
                src_rec.push_back(int'(out_src));
            end
        end
        chk("tput_beats", 64'(cyc_rec.size()), 64'(8));
        for (int i = 1; i < cyc_rec.size(); i++) begin
            chk("tput_gap", 64'(cyc_rec[i] - cyc_rec[i-1]), 64'(2));
            chk("tput_alt", 64'(src_rec[i]), 64'(1 - src_rec[i-1]));
        end
        wait_drain(100);

        // Client 1 mid-packet with bubbles while client 3 requests: no interleaving.
        bubble_pct = 40;
        post_pkt(1, 4);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (busy) found = 1;
        end
        chk("lock_seen", 64'(found), 64'(1));
        post_pkt(3, 2);
        wait_drain(300);
        bubble_pct = 0;

        // Bad multi-hot grant: stay idle, sticky error.
        @(posedge clk);
        #1;
        bad_gnt   = 4'b0011;
        force_bad = 1;
        post_pkt(0, 1);
        post_pkt(1, 1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (in_valid == 4'b0011) found = 1;
        end
        chk("bad_start", 64'(found), 64'(1));
        chk("bad_err_before", 64'(gnt_err), 64'(0));
        chk("bad_busy0", 64'(busy), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bad_busy", 64'(busy), 64'(0));
            chk("bad_err", 64'(gnt_err), 64'(1));
        end
        @(posedge clk);
        #1;
        force_bad = 0;
        wait_drain(100);
        chk("bad_err_sticky", 64'(gnt_err), 64'(1));

        // Reset after beat 2 of a 4-beat packet: everything cleared, then normal service.
        base = out_beats;
        post_pkt(3, 4);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (out_beats >= base + 2) found = 1;
        end
        chk("rst_mid_reach", 64'(found), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush = 1;
        #1;
        chk("rst_mid_ov", 64'(out_valid), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_mid_err", 64'(gnt_err), 64'(0));
        for (int k = 0; k < CLIENTS; k++) exp_q[k].delete();
        grant_q.delete();
        in_pkt    = 0;
        model_cnt = 16'd0;
        hold_prev = 0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        post_pkt(0, 2);
        wait_drain(100);
        chk("post_rst_cnt", 64'(pkt_cnt), 64'(1));

        // Random traffic with bubbles and output back-pressure.
        bubble_pct = 30;
        rand_ready = 1;
        for (int p = 0; p < 40; p++) begin
            post_pkt($urandom_range(CLIENTS - 1), $urandom_range(4, 1));
            repeat ($urandom_range(6)) @(posedge clk);
        end
        wait_drain(5000);
        rand_ready = 0;
        chk("final_grants", 64'(grant_q.size()), 64'(0));
        chk("final_cnt", 64'(pkt_cnt), 64'(model_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_pkt_mux.md
ARB_PKT_MUX -- requirements
Module: arb_pkt_mux

Interface
REQ-001 Parameter CLIENTS, default 4, number of requesting clients (2..16).
REQ-002 Parameter DATA_W, default 32, payload width per beat.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  CLIENTS  per-client beat valid.
REQ-006 in_ready  output  CLIENTS  per-client beat accept; at most one bit high per cycle.
REQ-007 in_data  input  CLIENTS*DATA_W  client k payload in bits [k*DATA_W +: DATA_W].
REQ-008 in_last  input  CLIENTS  per-client last-beat-of-packet flag.
REQ-009 arb_req  output  CLIENTS  request vector to the round-robin arbiter.
REQ-010 arb_gnt  input  CLIENTS  combinational one-hot grant returned by the arbiter in the same cycle.
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_data  output  DATA_W  output payload.
REQ-014 out_last  output  1  output last-beat flag.
REQ-015 out_src  output  $clog2(CLIENTS)  index of client that produced the output beat.
REQ-016 busy  output  1  high while state is LOCK.
REQ-017 gnt_err  output  1  sticky arbiter-protocol error flag.
REQ-018 pkt_cnt  output  16  count of packets delivered at the output.

Function
REQ-019 Block SHALL implement a two-state FSM: IDLE, LOCK; busy = (state == LOCK).
REQ-020 In IDLE, arb_req SHALL equal in_valid; in LOCK, arb_req SHALL be all-zero so the arbiter's rotation state does not advance mid-packet.
REQ-021 In IDLE, when arb_req != 0 and arb_gnt is one-hot and a subset of arb_req, the block SHALL register the granted index into sel and enter LOCK next cycle.
REQ-022 In IDLE, when arb_req != 0 and arb_gnt is zero, multi-hot, or has a bit outside arb_req, the block SHALL remain IDLE and set gnt_err the next cycle.
REQ-023 gnt_err SHALL remain set until reset.
REQ-024 In IDLE, in_ready SHALL be all-zero; no beat is accepted in the arbitration cycle.
REQ-025 In LOCK, in_ready[sel] SHALL equal (!out_valid || out_ready); all other in_ready bits SHALL be 0.
REQ-026 An input beat transfers when in_valid[sel] && in_ready[sel]; the payload, last flag and sel SHALL load into the output register, setting out_valid the next cycle.
REQ-027 Output register SHALL be a single stage: out_valid clears on out_ready when no new beat loads in the same cycle; simultaneous drain and load SHALL keep out_valid high with the new beat.
REQ-028 out_data, out_last and out_src SHALL hold stable while out_valid && !out_ready.
REQ-029 An input transfer with in_last[sel] = 1 SHALL return the FSM to IDLE next cycle; arbitration for the next packet SHALL overlap draining of the output register.
REQ-030 Client deasserting in_valid[sel] mid-packet SHALL leave the FSM in LOCK indefinitely; no other client is served until that packet's last beat.
REQ-031 Minimum latency: arbitration cycle N, input transfer cycle N+1, out_valid high cycle N+2.
REQ-032 Single-beat packets from back-to-back clients with out_ready held high SHALL achieve one beat per two cycles.
REQ-033 pkt_cnt SHALL increment by 1 on each output transfer with out_last = 1 and saturate at 16'hFFFF.
REQ-034 Changes of in_valid on non-selected clients during LOCK SHALL have no effect on any output.

Reset
REQ-035 On rst_n low, asynchronously: state = IDLE, sel = 0, out_valid = 0, out_data = 0, out_last = 0, out_src = 0, gnt_err = 0, pkt_cnt = 0.
REQ-036 Reset asserted mid-packet SHALL discard the partial packet and any held output beat; after release the block behaves as after power-on.

Verification
REQ-037 Client 2 sends a 3-beat packet (A,B,C, last on C), out_ready=1 -> out_data A,B,C on consecutive cycles, out_src=2, out_last only with C, pkt_cnt=1.
REQ-038 Clients 0 and 1 both send single-beat packets continuously, out_ready=1 -> out_src alternates 0,1,0,1; one beat per two cycles.
REQ-039 Client 1 mid-packet while client 3 asserts valid -> no client-3 beat until client 1 last beat accepted; arb_req = 0 throughout LOCK.
REQ-040 out_ready low for 5 cycles with a beat held -> out_data/out_last/out_src stable, in_ready[sel] = 0 for those cycles.
REQ-041 arb_gnt forced to 4'b0011 with in_valid = 4'b0011 -> FSM stays IDLE, gnt_err = 1 next cycle and remains 1.
REQ-042 rst_n pulsed low after beat 2 of a 4-beat packet -> out_valid = 0, busy = 0, pkt_cnt = 0 immediately; next packet delivered normally.
